// File: rtl/inst_issuer_pkg.sv
// inst_issuer_pkg: shared types and constants for the instruction issuer.
// Holds the FSM state type, the inst field layout and the default
// execution-window length.
package inst_issuer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int INST_W      = 32;
    localparam int BODY_W      = 31;
    localparam int EXECUTE_BIT = 31;

    localparam int ALUMODE_MSB     = 30;
    localparam int ALUMODE_LSB     = 27;
    localparam int OPMODE_MSB      = 26;
    localparam int OPMODE_LSB      = 20;
    localparam int INMODE_MSB      = 19;
    localparam int INMODE_LSB      = 15;
    localparam int BRAM1_WADDR_MSB = 14;
    localparam int BRAM1_WADDR_LSB = 10;
    localparam int BRAM1_RADDR_MSB = 9;
    localparam int BRAM1_RADDR_LSB = 5;
    localparam int BRAM0_RADDR_MSB = 4;
    localparam int BRAM0_RADDR_LSB = 0;

    // Field view of an instruction word, laid out from the constants above.
    typedef struct packed {
        logic                                       execute;
        logic [ALUMODE_MSB-ALUMODE_LSB:0]           alumode;
        logic [OPMODE_MSB-OPMODE_LSB:0]             opmode;
        logic [INMODE_MSB-INMODE_LSB:0]             inmode;
        logic [BRAM1_WADDR_MSB-BRAM1_WADDR_LSB:0]   bram1_waddr;
        logic [BRAM1_RADDR_MSB-BRAM1_RADDR_LSB:0]   bram1_raddr;
        logic [BRAM0_RADDR_MSB-BRAM0_RADDR_LSB:0]   bram0_raddr;
    } inst_t;

    localparam int EXEC_CYCLES_DEFAULT = 5;

    // Build a full instruction word from the execute flag and a stored body.
    function automatic logic [INST_W-1:0] make_inst(input logic execute,
                                                    input logic [BODY_W-1:0] body);
        logic [INST_W-1:0] word;
        word                       = '0;
        word[EXECUTE_BIT]          = execute;
        word[EXECUTE_BIT-1:0]      = body;
        return word;
    endfunction

endpackage

// File: rtl/inst_issuer_prog_mem.sv
// inst_issuer_prog_mem: PROG_DEPTH x 31 program store.
// One synchronous write port, one asynchronous read port. Contents are
// deliberately not reset so a program survives a controller reset.
module inst_issuer_prog_mem
    import inst_issuer_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    localparam int ADDR_W    = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BODY_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BODY_W-1:0] rdata
);

    logic [BODY_W-1:0] mem [PROG_DEPTH];

    // Program slot write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_issuer.sv
// inst_issuer: sequences stored instruction bodies onto the 32-bit inst bus,
// holding execute high for EXEC_CYCLES then one idle gap per instruction.
// Optional build macro INST_ISSUER_LOOP_EN adds loop/stop ports for
// continuous re-issue of the program until stopped.
//
// state | meaning
// IDLE  | accepting program writes and start; inst=0
// EXEC  | issuing prog[idx] with execute=1, window down-counter running
// GAP   | one cycle, same body with execute=0, then advance idx
// FIN   | one cycle, done pulse, inst=0
module inst_issuer
    import inst_issuer_pkg::*;
#(
    parameter int PROG_DEPTH  = 16,
    parameter int EXEC_CYCLES = EXEC_CYCLES_DEFAULT,
    localparam int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [BODY_W-1:0] prog_data,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
`ifdef INST_ISSUER_LOOP_EN
    input  logic              loop,
    input  logic              stop,
`endif
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam int CYC_W = $clog2(EXEC_CYCLES + 1);
    localparam logic [CYC_W-1:0]  CYC_LOAD = CYC_W'(EXEC_CYCLES - 1);
    localparam logic [ADDR_W:0]   N_MAX    = (ADDR_W + 1)'(PROG_DEPTH);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W:0]     n;
    logic [CYC_W-1:0]    cyc;
    logic                start_pend;

    logic [ADDR_W:0]     idx_next;
    logic                last;
    logic                wrap;
    logic                end_run;
    logic [ADDR_W-1:0]   rd_addr;
    logic [BODY_W-1:0]   rd_data;
    logic                mem_we;

`ifdef INST_ISSUER_LOOP_EN
    logic                loop_q;
    logic                stop_req;
    logic                stop_now;
`endif

    // Next-slot decode for the GAP exit; the read port is pointed at the
    // slot about to be issued so inst can be loaded on the same edge.
    always_comb begin
        idx_next = {1'b0, idx} + 1'b1;
        last     = (idx_next == n);
`ifdef INST_ISSUER_LOOP_EN
        stop_now = stop_req | stop;
        wrap     = last & loop_q & ~stop_now;
        end_run  = (last & ~wrap) | stop_now;
`else
        wrap     = 1'b0;
        end_run  = last;
`endif
        rd_addr  = '0;
        if (state == ST_GAP && !last) begin
            rd_addr = idx_next[ADDR_W-1:0];
        end
    end

    // Writes only land while idle so a running program is never disturbed.
    assign mem_we = prog_we & (state == ST_IDLE);

    inst_issuer_prog_mem #(
        .PROG_DEPTH (PROG_DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Sequencer FSM with registered inst/busy/done. A start is first
    // captured in start_pend, which gives the one-cycle start latency and
    // lets a same-cycle write to slot 0 be seen by the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            n          <= '0;
            cyc        <= '0;
            start_pend <= 1'b0;
            inst       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef INST_ISSUER_LOOP_EN
            loop_q     <= 1'b0;
            stop_req   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_pend) begin
                        start_pend <= 1'b0;
                        idx        <= '0;
                        busy       <= 1'b1;
                        if (n == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            inst  <= '0;
                        end else begin
                            state <= ST_EXEC;
                            cyc   <= CYC_LOAD;
                            inst  <= make_inst(1'b1, rd_data);
                        end
                    end else if (start) begin
                        start_pend <= 1'b1;
                        n          <= (count > N_MAX) ? N_MAX : count;
`ifdef INST_ISSUER_LOOP_EN
                        loop_q     <= loop;
                        stop_req   <= 1'b0;
`endif
                    end
                end
                ST_EXEC: begin
`ifdef INST_ISSUER_LOOP_EN
                    if (stop) begin
                        stop_req <= 1'b1;
                    end
`endif
                    if (cyc == '0) begin
                        state             <= ST_GAP;
                        inst[EXECUTE_BIT] <= 1'b0;
                    end else begin
                        cyc <= cyc - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (end_run) begin
                        state <= ST_FIN;
                        inst  <= '0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_EXEC;
                        idx   <= wrap ? '0 : idx_next[ADDR_W-1:0];
                        cyc   <= CYC_LOAD;
                        inst  <= make_inst(1'b1, rd_data);
                        done  <= wrap;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    inst  <= '0;
`ifdef INST_ISSUER_LOOP_EN
                    stop_req <= 1'b0;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    inst  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_issuer.sv
// tb_inst_issuer: randomized self-checking bench for inst_issuer.
module tb_inst_issuer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int EC    = 5;
    localparam int PER   = EC + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [30:0]   prog_data;
    logic          start;
    logic [AW:0]   count;
    logic [31:0]   inst;
    logic          busy;
    logic          done;
`ifdef INST_ISSUER_LOOP_EN
    logic          loop;
    logic          stop;
`endif

    int checks   = 0;
    int failures = 0;

    logic [30:0] prog_m [DEPTH];
    logic [33:0] obs_q [$];

    inst_issuer #(
        .PROG_DEPTH  (DEPTH),
        .EXEC_CYCLES (EC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .count     (count),
`ifdef INST_ISSUER_LOOP_EN
        .loop      (loop),
        .stop      (stop),
`endif
        .inst      (inst),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Length of a run's busy period in cycles.
    function automatic int run_len(input int n);
        return (n == 0) ? 1 : n * PER + 1;
    endfunction

    // Expected {busy, done, inst} at t cycles after the start-sampling edge.
    function automatic logic [33:0] expect_at(input int n, input int t);
        int total, i, ph;
        total = run_len(n);
        if (t < 1 || t > total) return 34'h0;
        if (t == total) return {1'b1, 1'b1, 32'h0};
        i  = (t - 1) / PER;
        ph = (t - 1) % PER;
        return {1'b1, 1'b0, (ph < EC), prog_m[i]};
    endfunction

    task automatic write_slot(input int addr, input logic [30:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        prog_m[addr] = data;
    endtask

    // Pulse start and record outputs for t=0..total+1. On cycle dcyc a
    // program write to dis_addr and a stray start are driven (dcyc=0: none).
    // wr0 drives a write of wr0_data to slot 0 alongside start.
    task automatic run_program(input int cnt, input int dcyc, input int dis_addr,
                               input bit wr0, input logic [30:0] wr0_data);
        int total;
        total = run_len(cnt);
        start = 1'b1;
        count = (AW + 1)'(cnt);
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = wr0_data;
        end
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        obs_q.delete();
        obs_q.push_back({busy, done, inst});
        for (int t = 1; t <= total + 1; t++) begin
            @(posedge clk); #1;
            obs_q.push_back({busy, done, inst});
            if (t == dcyc) begin
                prog_we   = 1'b1;
                prog_addr = AW'(dis_addr);
                prog_data = 31'($urandom);
                start     = 1'b1;
                count     = (AW + 1)'($urandom_range(1, DEPTH));
            end else begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
        end
        prog_we = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, inst} !== 34'h0) begin
            failures++;
            $display("FAIL reset_hold got busy/done/inst=%h want 0", {busy, done, inst});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, inst} !== 34'h0) begin
            failures++;
            $display("FAIL reset_idle got busy/done/inst=%h want 0", {busy, done, inst});
        end
        for (int s = 0; s < DEPTH; s++) write_slot(s, 31'($urandom));
    endtask

    task automatic test_directed_run();
        int done_t;
        write_slot(0, 31'h1);
        write_slot(1, 31'h22);
        write_slot(2, 31'h333);
        run_program(3, 0, 0, 1'b0, '0);
        done_t = -1;
        for (int t = 0; t < obs_q.size(); t++) begin
            if (obs_q[t][32] === 1'b1 && done_t < 0) done_t = t;
            checks++;
            if (obs_q[t] !== expect_at(3, t)) begin
                failures++;
                $display("FAIL directed t=%0d got %h want %h", t, obs_q[t], expect_at(3, t));
            end
        end
        checks++;
        if (done_t != 19) begin
            failures++;
            $display("FAIL directed_done_cycle got %0d want 19", done_t);
        end
    endtask

    task automatic test_count_zero();
        run_program(0, 0, 0, 1'b0, '0);
        for (int t = 0; t < obs_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== expect_at(0, t)) begin
                failures++;
                $display("FAIL count_zero t=%0d got %h want %h", t, obs_q[t], expect_at(0, t));
            end
        end
    endtask

    task automatic test_busy_ignore();
        write_slot(1, 31'h0ABCDEF);
        run_program(2, 3, 1, 1'b0, '0);
        for (int t = 0; t < obs_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== expect_at(2, t)) begin
                failures++;
                $display("FAIL busy_ignore t=%0d got %h want %h", t, obs_q[t], expect_at(2, t));
            end
        end
        run_program(2, 0, 0, 1'b0, '0);
        checks++;
        if (obs_q[PER + 1] !== {2'b10, 1'b1, 31'h0ABCDEF}) begin
            failures++;
            $display("FAIL busy_ignore_readback got %h want %h", obs_q[PER + 1],
                     {2'b10, 1'b1, 31'h0ABCDEF});
        end
    endtask

    task automatic test_write_with_start();
        logic [30:0] d;
        d = 31'($urandom);
        prog_m[0] = d;
        run_program(2, 0, 0, 1'b1, d);
        for (int t = 0; t < obs_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== expect_at(2, t)) begin
                failures++;
                $display("FAIL write_with_start t=%0d got %h want %h", t, obs_q[t], expect_at(2, t));
            end
        end
    endtask

    task automatic test_random_runs();
        int cnt, dcyc;
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 3; w++) write_slot($urandom_range(0, DEPTH - 1), 31'($urandom));
            cnt  = $urandom_range(0, DEPTH);
            dcyc = $urandom_range(1, run_len(cnt));
            run_program(cnt, dcyc, $urandom_range(0, DEPTH - 1), 1'b0, '0);
            for (int t = 0; t < obs_q.size(); t++) begin
                checks++;
                if (obs_q[t] !== expect_at(cnt, t)) begin
                    failures++;
                    $display("FAIL random it=%0d n=%0d t=%0d got %h want %h",
                             it, cnt, t, obs_q[t], expect_at(cnt, t));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        n1 = $urandom_range(1, 4);
        n2 = $urandom_range(1, 4);
        run_program(n1, run_len(n1), 2, 1'b0, '0);
        for (int t = 0; t < obs_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== expect_at(n1, t)) begin
                failures++;
                $display("FAIL b2b_first t=%0d got %h want %h", t, obs_q[t], expect_at(n1, t));
            end
        end
        run_program(n2, 0, 0, 1'b0, '0);
        for (int t = 0; t < obs_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== expect_at(n2, t)) begin
                failures++;
                $display("FAIL b2b_second t=%0d got %h want %h", t, obs_q[t], expect_at(n2, t));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        count = (AW + 1)'(3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, done, inst} !== expect_at(3, 2)) begin
            failures++;
            $display("FAIL reset_mid_pre got %h want %h", {busy, done, inst}, expect_at(3, 2));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, inst} !== 34'h0) begin
            failures++;
            $display("FAIL reset_mid_async got %h want 0", {busy, done, inst});
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_program(1, 0, 0, 1'b0, '0);
        for (int t = 0; t < obs_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== expect_at(1, t)) begin
                failures++;
                $display("FAIL reset_restart t=%0d got %h want %h", t, obs_q[t], expect_at(1, t));
            end
        end
    endtask

`ifdef INST_ISSUER_LOOP_EN
    task automatic test_loop_stop();
        logic [33:0] exp;
        int i, ph;
        loop  = 1'b1;
        start = 1'b1;
        count = (AW + 1)'(2);
        @(posedge clk); #1;
        start = 1'b0;
        loop  = 1'b0;
        for (int t = 1; t <= 44; t++) begin
            @(posedge clk); #1;
            stop = (t == 38);
            i  = ((t - 1) / PER) % 2;
            ph = (t - 1) % PER;
            if (t == 43)      exp = {1'b1, 1'b1, 32'h0};
            else if (t == 44) exp = 34'h0;
            else              exp = {1'b1, (t > 1 && (t - 1) % (2 * PER) == 0), (ph < EC), prog_m[i]};
            checks++;
            if ({busy, done, inst} !== exp) begin
                failures++;
                $display("FAIL loop_stop t=%0d got %h want %h", t, {busy, done, inst}, exp);
            end
        end
        stop = 1'b0;
    endtask
`endif

    initial begin
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        count     = '0;
`ifdef INST_ISSUER_LOOP_EN
        loop      = 1'b0;
        stop      = 1'b0;
`endif
        test_reset();
        test_directed_run();
        test_count_zero();
        test_busy_ignore();
        test_write_with_start();
        test_random_runs();
        test_back_to_back();
        test_reset_mid_run();
`ifdef INST_ISSUER_LOOP_EN
        test_loop_stop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_issuer.md
# inst_issuer

Instruction sequencer driving the 32-bit `inst` word consumed by the BRAM/DSP datapath controller. It stores a short program of 31-bit instruction bodies (`dsp_alumode`/`dsp_opmode`/`dsp_inmode`/`bram1_waddr`/`bram1_raddr`/`bram0_raddr` fields). On `start` it issues them in order, holding `execute` (bit 31) high for the controller's fixed execution window and inserting an idle gap between instructions. It sits between the host/test harness and the controller, replacing hand-driven `inst` stimulus.

## Interface
Parameters:
- `PROG_DEPTH`, 16: number of program slots; power of two, at least 2.
- `EXEC_CYCLES`, 5: cycles each instruction is held with `execute`=1.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `prog_we`, in, 1: program write strobe.
- `prog_addr`, in, `$clog2(PROG_DEPTH)`: program slot being written.
- `prog_data`, in, 31: instruction body, i.e. `inst[30:0]`.
- `start`, in, 1: one-cycle request to run the program.
- `count`, in, `$clog2(PROG_DEPTH)+1`: number of instructions to issue, 0..`PROG_DEPTH`. Sampled with `start`.
- `inst`, out, 32: registered instruction word to the controller.
- `busy`, out, 1: high while a run is in progress.
- `done`, out, 1: one-cycle pulse when a run completes.

## Operation
- States: IDLE, EXEC, GAP, FIN.
- IDLE:
  - `prog_we`=1 writes `prog_data` into slot `prog_addr`.
  - `start`=1 with `count`>0: latch `count` into `n`, set `idx`=0, go to EXEC.
  - `start`=1 with `count`=0: go to FIN directly. No instruction is issued.
- EXEC:
  - `inst` = {1, `prog[idx]`}.
  - A cycle counter runs 0..`EXEC_CYCLES`-1. At the terminal count, go to GAP.
- GAP: one cycle.
  - `inst` = {0, `prog[idx]`}; body unchanged, `execute` dropped.
  - Then `idx`+1; if `idx`+1 == `n`, go to FIN, else go to EXEC.
- FIN: one cycle. `done`=1, `inst`=0, then go to IDLE.
- `busy`=1 in EXEC, GAP and FIN.
- `prog_we` while `busy`: the write is dropped; program contents are unchanged.
- `start` while `busy`: ignored.
- `idx` never wraps within a run, because `n` ≤ `PROG_DEPTH`.
- Reset, including mid-run:
  - State goes to IDLE; `inst`=0, `busy`=0, `done`=0; `idx`, `n` and the cycle counter clear.
  - Program contents are not reset. They hold their previous value, or X after power-up.

## Timing
- `start` sampled high at edge k: `inst[31]`=1 and `busy`=1 are visible after edge k+1.
- Each instruction occupies `EXEC_CYCLES`+1 cycles: `EXEC_CYCLES` with `execute`=1, then 1 gap cycle.
- A run of N>0 instructions has `busy` high for N·(`EXEC_CYCLES`+1)+1 cycles. The last of these is the FIN cycle, which carries `done`.
- `count`=0: `done` is visible after edge k+1, with `busy` high for that single cycle.
- `inst` changes only on a clock edge. The body field is stable across an instruction's EXEC and GAP cycles.
- The earliest next `start` is accepted in the cycle after `done`.
- A `prog_we` in the same cycle as `start` in IDLE is accepted. The write lands at edge k, so a write to slot 0 is issued by this run.

## Configuration
- `INST_ISSUER_LOOP_EN` defined:
  - Adds input `loop` (1 bit), sampled with `start`.
  - If `loop` was set, then on leaving the GAP of the last instruction, `idx` returns to 0 and the state goes to EXEC instead of FIN. `done` pulses on every wrap.
  - The run ends only via a new input `stop` (1 bit). `stop` finishes the current instruction, including its GAP, then goes to FIN.
- Macro undefined: the `loop` and `stop` ports are absent; behaviour is as above.

## Structure
- Shared package `inst_issuer_pkg` holds:
  - State enum.
  - Bit-position constants for the `inst` fields: EXECUTE_BIT=31; ALUMODE 30:27; OPMODE 26:20; INMODE 19:15; BRAM1_WADDR 14:10; BRAM1_RADDR 9:5; BRAM0_RADDR 4:0.
  - Default `EXEC_CYCLES`.
- Sub-module `inst_issuer_prog_mem`: a `PROG_DEPTH`×31 register file with one write port and one asynchronous read port.

## Test plan
- Reset then idle → `inst`=0, `busy`=0, `done`=0.
- Write slots 0..2 = 0x1, 0x22, 0x333; `start`, `count`=3 → three windows of `inst`=0x80000001/0x80000022/0x80000333, 5 cycles each. Each window is followed by 1 cycle with bit31=0. `done` pulses at cycle 19 after `start`.
- `start`, `count`=0 → no `execute`; `done` asserted 1 cycle after `start`.
- Assert `prog_we` to slot 1 and pulse `start` mid-run → program and run are unaffected; write readback after the run shows the old value.
- Drop `rst_n` during the second EXEC cycle → `inst`=0 and `busy`=0 immediately. A restart issues slot 0 first.
- `INST_ISSUER_LOOP_EN`: `count`=2, `loop`=1 → slots 0,1,0,1… with `done` every 12 cycles. `stop` during slot 0 → slot 0 completes its GAP, then FIN.
